ctrl_seq: RTL and testbench
===========================

Name: ctrl_seq

Overview:
- SAP-1 controller/sequencer. Sits directly upstream of the display decoder and output register.
- Generates the machine's control word each T-state, including opr_in (the output-register load strobe consumed by the display decoder).
- A 6-state one-hot ring counter is decoded against the current IR opcode to run fetch (T1–T3) and execute (T4–T6).
- On HLT, latches halted and freezes the machine until reset.

Parameters:
- RING_LEN, 6: number of T-states per instruction; fixed at 6 for SAP-1; other values unsupported.
- OPC_W, 4: opcode width (IR upper nibble).

Ports:
- clk  in  1  system clock; ring counter advances on the falling edge.
- cls  in  1  reset; asynchronous, active-high. One clock; reset is asynchronous and active-high.
- opcode  in  OPC_W  current instruction register upper nibble.
- tstate  out  RING_LEN  one-hot T-state (bit0 = T1).
- cp  out  1  program counter increment.
- ep  out  1  program counter drives BUS.
- lm  out  1  MAR load.
- ce  out  1  RAM drives BUS.
- li  out  1  IR load.
- ei  out  1  IR operand nibble drives BUS.
- la  out  1  accumulator load.
- ea  out  1  accumulator drives BUS.
- su  out  1  ALU subtract select.
- eu  out  1  ALU drives BUS.
- lb  out  1  B register load.
- opr_in  out  1  output register load; feeds the display stage.
- halt  out  1  machine halted; gates clk upstream.

Behaviour:
- All control outputs are active-high, combinational decode of (tstate, opcode, halted).
- tstate and halted are flops on negedge clk, so the control word is stable across the following posedge, where registers load.
- Reset (cls=1, any time, mid-instruction included): tstate=000001 (T1), halted=0; all control outputs reflect T1 decode (ep=1, lm=1, all others 0); halt=0.
- Ring advance: at each negedge, if !halted, tstate rotates left; T6 wraps to T1.
- Fetch (opcode-independent):
  - T1: ep, lm.
  - T2: cp.
  - T3: ce, li.
- Execute, by opcode:
  - LDA 0000: T4 ei, lm; T5 ce, la; T6 none.
  - ADD 0001: T4 ei, lm; T5 ce, lb; T6 eu, la.
  - SUB 0010: T4 ei, lm; T5 ce, lb; T6 su, eu, la.
  - OUT 1110: T4 ea, opr_in; T5 none; T6 none.
  - HLT 1111: T4 none. At the negedge ending T4, halted:=1 and tstate holds at T4.
  - Any other opcode: NOP; T4–T6 assert nothing; ring continues.
- Halted: all control outputs 0, halt=1, tstate frozen; exits only via cls.
- opcode is sampled combinationally. It must be stable from the posedge ending T3 (li) onward; opcode changes during T1–T3 do not affect fetch decode.
- Invariants:
  - At most one BUS driver (ep, ce, ei, ea, eu) asserted in any state.
  - opr_in asserts for exactly one T-state per OUT instruction.
- tstate is never all-zero or multi-hot. If an illegal value is detected, force T1 at the next negedge.

Optional Feature:
- Macro SAP_SINGLE_STEP_EN.
  - Defined: adds input step (1 bit, synchronous to clk). The ring advances at a negedge only when step=1 and !halted. While step=0, tstate holds and the control word remains asserted; the bench/board must gate clk to the datapath accordingly.
  - Undefined: no step port; the ring advances every negedge as above.
- Reset behaviour is identical in both builds.

Decomposition:
- Package sap_pkg:
  - opcode constants OPC_LDA, OPC_ADD, OPC_SUB, OPC_OUT, OPC_HLT.
  - T-state one-hot constants T1..T6.
  - Control-word bit index constants, for a packed 12-bit view.
- One sub-module: ring_counter, holding the one-hot rotate, hold enable, illegal-state recovery and async clear.
- Opcode decode stays in ctrl_seq.

Test Plan:
- Reset mid-T5 of ADD (cls pulse asynchronous to clk) -> tstate=000001 immediately; ep=lm=1, all else 0; halt=0.
- opcode=0000 (LDA) over 6 negedges -> tstate T1..T6 in order; T4 {ei,lm}, T5 {ce,la}, T6 all 0; wraps to T1.
- opcode=0010 (SUB) -> T6 asserts su=eu=la=1; ADD (0001) at T6 asserts eu=la=1, su=0.
- opcode=1110 (OUT) -> opr_in=1 only in T4, together with ea=1; opr_in=0 in all other states over 3 instructions.
- opcode=1111 (HLT) -> after T4, halt=1, all control 0, tstate stays 001000 for 20 clocks; cls returns to T1.
- opcode=0111 (undefined) -> T4–T6 all outputs 0, ring wraps normally. With SAP_SINGLE_STEP_EN and step=0 for 5 clocks, tstate unchanged; one step=1 cycle advances it by exactly one.

Source files
------------

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - SAP-1 opcodes, T-state encodings and control-word bit indices
package sap_pkg;

  localparam logic [3:0] OPC_LDA = 4'b0000;
  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_SUB = 4'b0010;
  localparam logic [3:0] OPC_OUT = 4'b1110;
  localparam logic [3:0] OPC_HLT = 4'b1111;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  // Packed control word, MSB first: cp ep lm ce li ei la ea su eu lb opr_in
  localparam int CW_W   = 12;
  localparam int CW_CP  = 11;
  localparam int CW_EP  = 10;
  localparam int CW_LM  = 9;
  localparam int CW_CE  = 8;
  localparam int CW_LI  = 7;
  localparam int CW_EI  = 6;
  localparam int CW_LA  = 5;
  localparam int CW_EA  = 4;
  localparam int CW_SU  = 3;
  localparam int CW_EU  = 2;
  localparam int CW_LB  = 1;
  localparam int CW_OPR = 0;

  typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - one-hot T-state ring on the falling edge with hold and illegal-state recovery
module ring_counter #(
  parameter int RING_LEN = 6
) (
  input  logic                clk,
  input  logic                cls,
  input  logic                adv,
  output logic [RING_LEN-1:0] tstate
);

  localparam logic [RING_LEN-1:0] FIRST = {{(RING_LEN-1){1'b0}}, 1'b1};

  logic [RING_LEN-1:0] ring;
  logic                legal;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign legal  = (ring != '0) && ((ring & (ring - FIRST)) == '0);
  assign tstate = ring;

  always_ff @(negedge clk or posedge cls) begin
    if (cls) begin
      ring <= FIRST;
    end else if (!legal) begin
      ring <= FIRST;
    end else if (adv) begin
      ring <= {ring[RING_LEN-2:0], ring[RING_LEN-1]};
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - SAP-1 controller/sequencer; SAP_SINGLE_STEP_EN adds a step input gating ring advance
module ctrl_seq
  import sap_pkg::*;
#(
  parameter int RING_LEN = 6,
  parameter int OPC_W    = 4
) (
  input  logic                clk,
  input  logic                cls,
`ifdef SAP_SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [OPC_W-1:0]    opcode,
  output logic [RING_LEN-1:0] tstate,
  output logic                cp,
  output logic                ep,
  output logic                lm,
  output logic                ce,
  output logic                li,
  output logic                ei,
  output logic                la,
  output logic                ea,
  output logic                su,
  output logic                eu,
  output logic                lb,
  output logic                opr_in,
  output logic                halt
);

  logic       halted;
  logic       step_ok;
  logic       hlt_end;
  logic       adv;
  ctrl_word_t cw;

`ifdef SAP_SINGLE_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  // HLT parks the ring on T4 instead of rotating; halted takes over from then on.
  assign hlt_end = (tstate == T4) && (opcode == OPC_HLT);
  assign adv     = step_ok && !halted && !hlt_end;

  ring_counter #(.RING_LEN(RING_LEN)) u_ring (
    .clk    (clk),
    .cls    (cls),
    .adv    (adv),
    .tstate (tstate)
  );

  always_ff @(negedge clk or posedge cls) begin
    if (cls) begin
      halted <= 1'b0;
    end else if (step_ok && hlt_end && !halted) begin
      halted <= 1'b1;
    end
  end

  always_comb begin
    cw = '0;
    if (!halted) begin
      case (tstate)
        T1: begin cw[CW_EP] = 1'b1; cw[CW_LM] = 1'b1; end
        T2: cw[CW_CP] = 1'b1;
        T3: begin cw[CW_CE] = 1'b1; cw[CW_LI] = 1'b1; end
        T4: begin
          case (opcode)
            OPC_LDA, OPC_ADD, OPC_SUB: begin cw[CW_EI] = 1'b1; cw[CW_LM] = 1'b1; end
            OPC_OUT: begin cw[CW_EA] = 1'b1; cw[CW_OPR] = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OPC_LDA: begin cw[CW_CE] = 1'b1; cw[CW_LA] = 1'b1; end
            OPC_ADD, OPC_SUB: begin cw[CW_CE] = 1'b1; cw[CW_LB] = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OPC_ADD: begin cw[CW_EU] = 1'b1; cw[CW_LA] = 1'b1; end
            OPC_SUB: begin cw[CW_SU] = 1'b1; cw[CW_EU] = 1'b1; cw[CW_LA] = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign cp     = cw[CW_CP];
  assign ep     = cw[CW_EP];
  assign lm     = cw[CW_LM];
  assign ce     = cw[CW_CE];
  assign li     = cw[CW_LI];
  assign ei     = cw[CW_EI];
  assign la     = cw[CW_LA];
  assign ea     = cw[CW_EA];
  assign su     = cw[CW_SU];
  assign eu     = cw[CW_EU];
  assign lb     = cw[CW_LB];
  assign opr_in = cw[CW_OPR];
  assign halt   = halted;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - directed and randomized checks of ctrl_seq against a T-state table model
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       cls = 1'b1;
  logic [3:0] opcode = 4'h0;
`ifdef SAP_SINGLE_STEP_EN
  logic       step = 1'b1;
`endif
  logic [5:0] tstate;
  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, opr_in, halt;

  int tests = 0;
  int fails = 0;
  int mt    = 1;
  bit mh    = 1'b0;

  always #5 clk = ~clk;

  ctrl_seq dut (
    .clk    (clk),
    .cls    (cls),
`ifdef SAP_SINGLE_STEP_EN
    .step   (step),
`endif
    .opcode (opcode),
    .tstate (tstate),
    .cp     (cp),
    .ep     (ep),
    .lm     (lm),
    .ce     (ce),
    .li     (li),
    .ei     (ei),
    .la     (la),
    .ea     (ea),
    .su     (su),
    .eu     (eu),
    .lb     (lb),
    .opr_in (opr_in),
    .halt   (halt)
  );

  // Signals asserted in T-state t for opcode op, as the instruction table lists them.
  function automatic logic [11:0] expected(int t, logic [3:0] op, bit h);
    bit xcp, xep, xlm, xce, xli, xei, xla, xea, xsu, xeu, xlb, xopr;
    {xcp, xep, xlm, xce, xli, xei, xla, xea, xsu, xeu, xlb, xopr} = '0;
    if (!h) begin
      if (t == 1) begin xep = 1; xlm = 1; end
      if (t == 2) xcp = 1;
      if (t == 3) begin xce = 1; xli = 1; end
      if (op == 4'b0000) begin
        if (t == 4) begin xei = 1; xlm = 1; end
        if (t == 5) begin xce = 1; xla = 1; end
      end
      if (op == 4'b0001 || op == 4'b0010) begin
        if (t == 4) begin xei = 1; xlm = 1; end
        if (t == 5) begin xce = 1; xlb = 1; end
        if (t == 6) begin xeu = 1; xla = 1; xsu = (op == 4'b0010); end
      end
      if (op == 4'b1110 && t == 4) begin xea = 1; xopr = 1; end
    end
    return {xcp, xep, xlm, xce, xli, xei, xla, xea, xsu, xeu, xlb, xopr};
  endfunction

  task automatic check(input string tag);
    logic [5:0]  et;
    logic [11:0] ew;
    logic [11:0] got;
    et  = 6'd1 << (mt - 1);
    ew  = expected(mt, opcode, mh);
    got = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, opr_in};
    tests++;
    assert (tstate === et) else begin
      fails++;
      $error("FAIL %s tstate observed=%b expected=%b", tag, tstate, et);
    end
    tests++;
    assert (got === ew) else begin
      fails++;
      $error("FAIL %s ctrl(cp ep lm ce li ei la ea su eu lb opr_in) observed=%b expected=%b", tag, got, ew);
    end
    tests++;
    assert (halt === mh) else begin
      fails++;
      $error("FAIL %s halt observed=%b expected=%b", tag, halt, mh);
    end
    tests++;
    assert ($countones({ep, ce, ei, ea, eu}) <= 1) else begin
      fails++;
      $error("FAIL %s bus_drivers observed=%b expected=at most one", tag, {ep, ce, ei, ea, eu});
    end
  endtask

  task automatic tick(input string tag);
    bit go;
    @(negedge clk);
    go = 1'b1;
`ifdef SAP_SINGLE_STEP_EN
    go = step;
`endif
    if (!mh && go) begin
      if (mt == 4 && opcode == 4'b1111) mh = 1'b1;
      else mt = (mt == 6) ? 1 : mt + 1;
    end
    #2;
    check(tag);
  endtask

  task automatic run_instr(input logic [3:0] op, input string tag);
    opcode = op;
    check(tag);
    repeat (6) tick(tag);
  endtask

  task automatic pulse_reset(input string tag);
    #1 cls = 1'b1;
    #1;
    mt = 1;
    mh = 1'b0;
    check(tag);
    cls = 1'b0;
  endtask

  initial begin
    #12;
    check("reset");
    #1 cls = 1'b0;

    run_instr(4'b0000, "lda");
    run_instr(4'b0010, "sub");
    run_instr(4'b0001, "add");
    repeat (3) run_instr(4'b1110, "out");
    run_instr(4'b0111, "nop");

    for (int i = 0; i < 16; i++) begin
      run_instr(4'($urandom_range(0, 14)), "rand");
    end

    opcode = 4'b0001;
    check("add_mid");
    repeat (4) tick("add_mid");
    pulse_reset("async_rst_t5");

    opcode = 4'b1111;
    check("hlt");
    repeat (4) tick("hlt");
    repeat (20) tick("hlt_hold");
    pulse_reset("hlt_reset");

`ifdef SAP_SINGLE_STEP_EN
    opcode = 4'b0000;
    tick("pre_step");
    step = 1'b0;
    repeat (5) tick("step_hold");
    step = 1'b1;
    tick("step_once");
    step = 1'b0;
    tick("step_hold2");
    step = 1'b1;
`endif

    run_instr(4'b0000, "lda_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
